id_ex_alu_issue: RTL
====================

Name: id_ex_alu_issue

Overview:
- ID/EX pipeline boundary that drives the ALU operand and control interface (r, s, aluc) of the pipeline CPU.
- Decodes the MIPS opcode/funct of the instruction leaving ID into the 4-bit ALU code and selects the operands.
- Registers the result into the EX stage, with stall/flush control.
- Applies MEM/WB forwarding to the registered operands, so the ALU always sees the correct r, s and aluc.

Parameters:
- DW, 32, datapath width.
- AW, 5, register-address width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  ID holds a real instruction.
- i_stall  in  1  hold the EX register (from the hazard unit).
- i_flush  in  1  load a bubble into EX.
- i_op  in  6  opcode.
- i_funct  in  6  funct field.
- i_shamt  in  5  shift amount.
- i_imm  in  16  immediate field.
- i_rs, i_rt, i_rd  in  AW  register indices.
- i_rs_val, i_rt_val  in  DW  register-file read data.
- i_mem_wen, i_mem_wa, i_mem_data  in  1/AW/DW  MEM-stage writeback (forward source 1).
- i_wb_wen, i_wb_wa, i_wb_data  in  1/AW/DW  WB-stage writeback (forward source 2).
- o_valid  out  1  EX holds a real instruction.
- o_r  out  DW  ALU first operand (i_r).
- o_s  out  DW  ALU second operand (i_s).
- o_aluc  out  4  ALU control (i_aluc).
- o_wen  out  1  EX result is written back.
- o_wa  out  AW  writeback index.
- o_store_data  out  DW  forwarded rt value for sw.
- o_illegal  out  1  one-cycle pulse; an unsupported instruction was squashed.

Behaviour:
- ALU codes:
  - ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOR=0101, SLT=0110, SLTU=0111.
  - LUI=1000: s<<16, r ignored.
  - SLL=1100, SRL=1101, SRA=1111: s shifted by r[4:0].
- Decode, R-type (op 000000):
  - funct 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU.
  - 000000/000010/000011 SLL/SRL/SRA with r = zero-extended shamt.
  - 000100/000110/000111 same codes with r = rs value.
  - Write index = rd.
- Decode, I-type (s = immediate, write index = rt):
  - addi/addiu ADD, sign-extended imm.
  - slti SLT / sltiu SLTU, sign-extended imm.
  - andi AND, ori OR, xori XOR, zero-extended imm.
  - lui LUI.
  - lw ADD, sign-extended imm.
- Decode, no writeback:
  - sw ADD, sign-extended imm, wen=0.
  - beq/bne SUB with s = rt value, wen=0.
- Decode, general:
  - Write index 0 forces wen=0.
  - Any other op/funct with i_valid=1: a bubble is loaded and o_illegal=1 for one cycle.
- EX register: operand *sources* (rs/rt index, shamt, extended imm, select flags), aluc, wen, wa and valid. Latency is one clock from ID to the ALU inputs.
- Forwarding is combinational after the register, applied to the rs and rt values:
  - Source is MEM if i_mem_wen and i_mem_wa == index != 0.
  - Else WB if i_wb_wen and i_wb_wa == index != 0.
  - Else the captured register-file value.
  - MEM beats WB when both match.
- Operand select: o_r = forwarded rs, or shamt for immediate shifts. o_s = forwarded rt, or the extended imm for I-type.
- Register update priority per edge: i_rst (async) > i_flush > i_stall > load.
  - Flush loads a bubble: valid=0, wen=0, wa=0, aluc=ADD, operand sources zero, so o_r=o_s=0.
  - Stall holds every field, but forwarding keeps re-evaluating each cycle.
  - Flush and stall together: flush wins.
  - i_valid=0 loads a bubble.
- o_illegal is registered and cleared on the next edge. It is not raised under flush, and it is held under stall without re-pulsing.
- Reset mid-operation: all outputs 0 immediately (o_aluc=ADD=0000, o_illegal=0); the EX register holds a bubble.

Decomposition:
- Package alu_pkg: ALU code constants, opcode/funct constants, and the decoded-control struct type.
- Sub-module alu_decode: purely combinational, op/funct → aluc, immediate-select/extend, shift-source, wen, wa, illegal.
- Top: the EX register and the forwarding muxes.

Test Plan:
- Reset mid-stream, then `sra $3,$2,4` with rt_val=F000_0000 → next cycle o_r=4, o_s=F000_0000, o_aluc=1111, o_wen=1, o_wa=3.
- `addi $5,$1,-1` with rs_val=10 → o_r=10, o_s=FFFF_FFFF, o_aluc=0000. `ori` with imm=8000 → o_s=0000_8000, o_aluc=0011.
- `add $4,$2,$3` with MEM writing $2=AAAA and WB writing $2=BBBB → o_r=AAAA. Same with MEM wa=0 → o_r=BBBB.
- i_stall=1 for 3 cycles while WB data changes → aluc/wa held, o_r tracks new forward data. Release → next instruction appears after 1 edge.
- i_flush with i_stall both 1 → o_valid=0, o_wen=0, o_aluc=0000. Undefined funct 111111 → bubble plus a single-cycle o_illegal.
- `sw` and `beq $0,$0` → o_wen=0. `add $0,$1,$2` → o_wen=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU control codes, MIPS opcode/funct encodings and the decoded-control record
// shared by the ID/EX issue stage and its decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic [3:0] aluc;
        logic       imm_sel;
        logic       shamt_sel;
        logic       wen;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of opcode/funct into ALU code, operand-source selects,
// extended immediate, writeback index/enable and an unsupported-instruction flag.
module alu_decode
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [5:0]    i_op,
    input  logic [5:0]    i_funct,
    input  logic [15:0]   i_imm,
    input  logic [AW-1:0] i_rt,
    input  logic [AW-1:0] i_rd,
    output dec_t          o_ctrl,
    output logic [DW-1:0] o_imm_ext,
    output logic [AW-1:0] o_wa
);

    logic          legal_s;
    logic          sign_ext_s;
    logic          wen_s;
    logic [AW-1:0] wa_s;
    dec_t          ctrl_s;

    // Opcode/funct table; anything not listed is flagged illegal.
    always_comb begin
        ctrl_s     = '0;
        ctrl_s.aluc = ALU_ADD;
        legal_s    = 1'b1;
        sign_ext_s = 1'b0;
        wen_s      = 1'b1;
        wa_s       = i_rt;
        case (i_op)
            OP_RTYPE: begin
                wa_s = i_rd;
                case (i_funct)
                    FN_ADD, FN_ADDU: ctrl_s.aluc = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl_s.aluc = ALU_SUB;
                    FN_AND:          ctrl_s.aluc = ALU_AND;
                    FN_OR:           ctrl_s.aluc = ALU_OR;
                    FN_XOR:          ctrl_s.aluc = ALU_XOR;
                    FN_NOR:          ctrl_s.aluc = ALU_NOR;
                    FN_SLT:          ctrl_s.aluc = ALU_SLT;
                    FN_SLTU:         ctrl_s.aluc = ALU_SLTU;
                    FN_SLL: begin ctrl_s.aluc = ALU_SLL; ctrl_s.shamt_sel = 1'b1; end
                    FN_SRL: begin ctrl_s.aluc = ALU_SRL; ctrl_s.shamt_sel = 1'b1; end
                    FN_SRA: begin ctrl_s.aluc = ALU_SRA; ctrl_s.shamt_sel = 1'b1; end
                    FN_SLLV:         ctrl_s.aluc = ALU_SLL;
                    FN_SRLV:         ctrl_s.aluc = ALU_SRL;
                    FN_SRAV:         ctrl_s.aluc = ALU_SRA;
                    default:         legal_s = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                ctrl_s.imm_sel = 1'b1;
                sign_ext_s     = 1'b1;
            end
            OP_SLTI: begin
                ctrl_s.aluc    = ALU_SLT;
                ctrl_s.imm_sel = 1'b1;
                sign_ext_s     = 1'b1;
            end
            OP_SLTIU: begin
                ctrl_s.aluc    = ALU_SLTU;
                ctrl_s.imm_sel = 1'b1;
                sign_ext_s     = 1'b1;
            end
            OP_ANDI: begin ctrl_s.aluc = ALU_AND; ctrl_s.imm_sel = 1'b1; end
            OP_ORI:  begin ctrl_s.aluc = ALU_OR;  ctrl_s.imm_sel = 1'b1; end
            OP_XORI: begin ctrl_s.aluc = ALU_XOR; ctrl_s.imm_sel = 1'b1; end
            OP_LUI:  begin ctrl_s.aluc = ALU_LUI; ctrl_s.imm_sel = 1'b1; end
            OP_SW: begin
                ctrl_s.imm_sel = 1'b1;
                sign_ext_s     = 1'b1;
                wen_s          = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_s.aluc = ALU_SUB;
                wen_s       = 1'b0;
            end
            default: legal_s = 1'b0;
        endcase
        ctrl_s.wen     = wen_s && legal_s && (wa_s != '0);
        ctrl_s.illegal = ~legal_s;
    end

    assign o_ctrl    = ctrl_s;
    assign o_wa      = wa_s;
    assign o_imm_ext = sign_ext_s ? {{(DW-16){i_imm[15]}}, i_imm}
                                  : {{(DW-16){1'b0}}, i_imm};

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX boundary: decodes the ID instruction, registers its operand sources and
// control into EX, then forwards MEM/WB results into the ALU operands.
module id_ex_alu_issue
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic          i_stall,
    input  logic          i_flush,
    input  logic [5:0]    i_op,
    input  logic [5:0]    i_funct,
    input  logic [4:0]    i_shamt,
    input  logic [15:0]   i_imm,
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rt,
    input  logic [AW-1:0] i_rd,
    input  logic [DW-1:0] i_rs_val,
    input  logic [DW-1:0] i_rt_val,
    input  logic          i_mem_wen,
    input  logic [AW-1:0] i_mem_wa,
    input  logic [DW-1:0] i_mem_data,
    input  logic          i_wb_wen,
    input  logic [AW-1:0] i_wb_wa,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_valid,
    output logic [DW-1:0] o_r,
    output logic [DW-1:0] o_s,
    output logic [3:0]    o_aluc,
    output logic          o_wen,
    output logic [AW-1:0] o_wa,
    output logic [DW-1:0] o_store_data,
    output logic          o_illegal
);

    // An all-zero record is a bubble: aluc=ADD and index 0 never forwards.
    typedef struct packed {
        logic          valid;
        logic [3:0]    aluc;
        logic          wen;
        logic [AW-1:0] wa;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [4:0]    shamt;
        logic [DW-1:0] imm;
        logic          imm_sel;
        logic          shamt_sel;
    } ex_t;

    dec_t          dec_s;
    logic [DW-1:0] imm_ext_s;
    logic [AW-1:0] dec_wa_s;
    ex_t           ex_q, ex_d;
    logic          illegal_q, illegal_d;
    logic [DW-1:0] rs_fwd_s, rt_fwd_s;

    function automatic logic [DW-1:0] fwd_pick(
        input logic [AW-1:0] idx,
        input logic [DW-1:0] rf_val,
        input logic          mem_wen,
        input logic [AW-1:0] mem_wa,
        input logic [DW-1:0] mem_data,
        input logic          wb_wen,
        input logic [AW-1:0] wb_wa,
        input logic [DW-1:0] wb_data
    );
        logic [DW-1:0] val;
        if (idx != '0 && mem_wen && mem_wa == idx) begin
            val = mem_data;
        end else if (idx != '0 && wb_wen && wb_wa == idx) begin
            val = wb_data;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    alu_decode #(.DW(DW), .AW(AW)) u_decode (
        .i_op      (i_op),
        .i_funct   (i_funct),
        .i_imm     (i_imm),
        .i_rt      (i_rt),
        .i_rd      (i_rd),
        .o_ctrl    (dec_s),
        .o_imm_ext (imm_ext_s),
        .o_wa      (dec_wa_s)
    );

    // Next EX contents: flush beats stall beats load; illegal or idle ID loads a bubble.
    always_comb begin
        ex_d      = ex_q;
        illegal_d = illegal_q;
        if (i_flush) begin
            ex_d      = '0;
            illegal_d = 1'b0;
        end else if (i_stall) begin
            ex_d      = ex_q;
            illegal_d = illegal_q;
        end else if (i_valid && !dec_s.illegal) begin
            ex_d.valid     = 1'b1;
            ex_d.aluc      = dec_s.aluc;
            ex_d.wen       = dec_s.wen;
            ex_d.wa        = dec_wa_s;
            ex_d.rs        = i_rs;
            ex_d.rt        = i_rt;
            ex_d.rs_val    = i_rs_val;
            ex_d.rt_val    = i_rt_val;
            ex_d.shamt     = i_shamt;
            ex_d.imm       = imm_ext_s;
            ex_d.imm_sel   = dec_s.imm_sel;
            ex_d.shamt_sel = dec_s.shamt_sel;
            illegal_d      = 1'b0;
        end else begin
            ex_d      = '0;
            illegal_d = i_valid && dec_s.illegal;
        end
    end

    // EX pipeline register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    // Forwarding is re-evaluated every cycle, including while EX is stalled.
    always_comb begin
        rs_fwd_s = fwd_pick(ex_q.rs, ex_q.rs_val, i_mem_wen, i_mem_wa, i_mem_data,
                            i_wb_wen, i_wb_wa, i_wb_data);
        rt_fwd_s = fwd_pick(ex_q.rt, ex_q.rt_val, i_mem_wen, i_mem_wa, i_mem_data,
                            i_wb_wen, i_wb_wa, i_wb_data);
    end

    assign o_r          = ex_q.shamt_sel ? {{(DW-5){1'b0}}, ex_q.shamt} : rs_fwd_s;
    assign o_s          = ex_q.imm_sel ? ex_q.imm : rt_fwd_s;
    assign o_store_data = rt_fwd_s;
    assign o_valid      = ex_q.valid;
    assign o_aluc       = ex_q.aluc;
    assign o_wen        = ex_q.wen;
    assign o_wa         = ex_q.wa;
    assign o_illegal    = illegal_q;

endmodule
